// File: rtl/prm_edge_query_seq_if.sv
// Request/response stream bundle between the PRM planner
// front-end (master) and the edge query sequencer (slave).
interface prm_edge_query_seq_if #(
  parameter int CODE_W = 15,
  parameter int OBS_N  = 16,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = $clog2(OBS_N);

  logic              req_valid;
  logic              req_ready;
  logic [CODE_W-1:0] req_base;
  logic [CNT_W-1:0]  req_count;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [CODE_W-1:0] rsp_code;
  logic              rsp_blocked;
  logic [IDX_W-1:0]  rsp_obs_idx;
  logic              rsp_last;

  modport master (
    output req_valid, req_base, req_count, rsp_ready,
    input  req_ready, rsp_valid, rsp_code,
    input  rsp_blocked, rsp_obs_idx, rsp_last
  );

  modport slave (
    input  req_valid, req_base, req_count, rsp_ready,
    output req_ready, rsp_valid, rsp_code,
    output rsp_blocked, rsp_obs_idx, rsp_last
  );
endinterface

// File: rtl/prm_edge_query_seq.sv
// Sweeps edge codes through the obstacle checker bank, one result per code.
// Optional PRM_EDGE_HIT_CNT_EN adds a saturating blocked-result counter.
module prm_edge_query_seq #(
  parameter int CODE_W  = 15,
  parameter int OBS_N   = 16,
  parameter int CHK_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  prm_edge_query_seq_if.slave bus,
  output logic [CODE_W-1:0]   chk_code,
  input  logic [OBS_N-1:0]    chk_mask,
  output logic                busy,
  output logic                done
`ifdef PRM_EDGE_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0]    hit_cnt
`endif
);
  localparam int IDX_W = $clog2(OBS_N);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  remaining;
  logic [2:0]        wcnt;
  logic [CODE_W-1:0] code_q;
  logic              blk_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx;

  logic acc, load, cap, dec_w, hs, adv, done_n;
  logic is_last;

  assign is_last = (remaining == CNT_W'(1));

  assign bus.req_ready   = rst_n && (state == IDLE);
  assign bus.rsp_valid   = (state == EMIT);
  assign bus.rsp_last    = (state == EMIT) && is_last;
  assign bus.rsp_code    = code_q;
  assign bus.rsp_blocked = blk_q;
  assign bus.rsp_obs_idx = idx_q;

  always_comb begin
    idx = '0;
    for (int i = OBS_N - 1; i >= 0; i--) begin
      if (chk_mask[i]) idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_n = state;
    acc     = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    dec_w   = 1'b0;
    hs      = 1'b0;
    adv     = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          acc = 1'b1;
          if (bus.req_count != '0) begin
            load    = 1'b1;
            state_n = WAIT;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (wcnt == '0) begin
          cap     = 1'b1;
          state_n = EMIT;
        end else begin
          dec_w = 1'b1;
        end
      end
      EMIT: begin
        // abort wins over a same-cycle handshake
        if (abort) begin
          state_n = IDLE;
        end else if (bus.rsp_ready) begin
          hs = 1'b1;
          if (is_last) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            adv     = 1'b1;
            state_n = WAIT;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      chk_code  <= '0;
      remaining <= '0;
      wcnt      <= '0;
      code_q    <= '0;
      blk_q     <= 1'b0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= done_n;
      if (load) begin
        remaining <= bus.req_count;
        chk_code  <= bus.req_base;
        wcnt      <= 3'(CHK_LAT);
      end
      if (dec_w) wcnt <= wcnt - 3'd1;
      if (cap) begin
        code_q <= chk_code;
        blk_q  <= |chk_mask;
        idx_q  <= idx;
      end
      if (hs) remaining <= remaining - CNT_W'(1);
      if (adv) begin
        chk_code <= chk_code + CODE_W'(1);
        wcnt     <= 3'(CHK_LAT);
      end
    end
  end

`ifdef PRM_EDGE_HIT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
    end else if (acc) begin
      hit_cnt <= '0;
    end else if (hs && blk_q && (hit_cnt != '1)) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Directed bench for prm_edge_query_seq with a combinational
// checker-bank stub: odd codes set mask bit (code & 0xF).
module tb_prm_edge_query_seq;
  localparam int CODE_W  = 15;
  localparam int OBS_N   = 16;
  localparam int CNT_W   = 16;
  localparam int CHK_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              abort = 1'b0;
  logic [CODE_W-1:0] chk_code;
  logic [OBS_N-1:0]  chk_mask;
  logic [OBS_N-1:0]  noise = '0;
  logic              busy;
  logic              done;
`ifdef PRM_EDGE_HIT_CNT_EN
  logic [CNT_W-1:0]  hit_cnt;
`endif

  int tests = 0;
  int fails = 0;

  prm_edge_query_seq_if #(
    .CODE_W(CODE_W), .OBS_N(OBS_N), .CNT_W(CNT_W)
  ) bus ();

  prm_edge_query_seq #(
    .CODE_W(CODE_W), .OBS_N(OBS_N),
    .CHK_LAT(CHK_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .bus(bus.slave),
    .chk_code(chk_code),
    .chk_mask(chk_mask),
    .busy(busy),
    .done(done)
`ifdef PRM_EDGE_HIT_CNT_EN
    ,
    .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    chk_mask = noise;
    if (chk_code[0]) chk_mask = (OBS_N'(1) << chk_code[3:0]) ^ noise;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [CODE_W-1:0] b,
                        input logic [CNT_W-1:0] c);
    bus.req_valid = 1'b1;
    bus.req_base  = b;
    bus.req_count = c;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok, output int n);
    n = 0;
    while (!bus.rsp_valid && n < 30) begin
      tick();
      n++;
    end
    ok = bus.rsp_valid;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        chk_code !== '0 || busy !== 1'b0 || done !== 1'b0 ||
        bus.rsp_last !== 1'b0 || bus.rsp_code !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b code=%h busy=%b done=%b, want all 0",
               bus.req_ready, bus.rsp_valid, chk_code, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_basic();
    logic [CODE_W-1:0] ec [3] = '{15'h0010, 15'h0011, 15'h0012};
    logic              eb [3] = '{1'b0, 1'b1, 1'b0};
    logic [3:0]        ei [3] = '{4'd0, 4'd1, 4'd0};
    bit ok;
    int n;
    bus.rsp_ready = 1'b1;
    accept(15'h0010, 16'd3);
    tests++;
    if (busy !== 1'b1 || chk_code !== 15'h0010 || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_accept: busy=%b code=%h vld=%b want 1/0010/0",
               busy, chk_code, bus.rsp_valid);
    end
    tick();
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_early_valid: got %b want 0 after 3 edges", bus.rsp_valid);
    end
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency: rsp_valid=%b want 1 after 4 edges", bus.rsp_valid);
    end
    for (int k = 0; k < 3; k++) begin
      wait_rsp(ok, n);
      tests++;
      if (!ok || (k > 0 && n != CHK_LAT + 1)) begin
        fails++;
        $display("FAIL basic_period%0d: ok=%0d gap=%0d want gap %0d",
                 k, ok, n, CHK_LAT + 1);
      end
      tests++;
      if (bus.rsp_code !== ec[k] || bus.rsp_blocked !== eb[k] ||
          bus.rsp_obs_idx !== ei[k] || bus.rsp_last !== (k == 2)) begin
        fails++;
        $display("FAIL basic_rsp%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b",
                 k, bus.rsp_code, bus.rsp_blocked, bus.rsp_obs_idx,
                 bus.rsp_last, ec[k], eb[k], ei[k], k == 2);
      end
      tick();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: done=%b busy=%b vld=%b want 1/0/0",
               done, busy, bus.rsp_valid);
    end
`ifdef PRM_EDGE_HIT_CNT_EN
    tests++;
    if (hit_cnt !== 16'd1) begin
      fails++;
      $display("FAIL basic_hit_cnt: got %0d want 1", hit_cnt);
    end
`endif
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_wrap();
    logic [CODE_W-1:0] ec [4] = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    bit ok;
    int n;
    bus.rsp_ready = 1'b1;
    accept(15'h7FFE, 16'd4);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(ok, n);
      tests++;
      if (!ok || bus.rsp_code !== ec[k] || bus.rsp_last !== (k == 3)) begin
        fails++;
        $display("FAIL wrap_rsp%0d: ok=%0d code=%h last=%b want %h/%b",
                 k, ok, bus.rsp_code, bus.rsp_last, ec[k], k == 3);
      end
      tick();
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wrap_done: got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    bus.rsp_ready = 1'b0;
    accept(15'h0021, 16'd1);
    wait_rsp(ok, n);
    for (int k = 0; k < 10; k++) begin
      noise = OBS_N'($urandom_range(1, 16'hFFFF));
      tick();
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_code !== 15'h0021 ||
          bus.rsp_blocked !== 1'b1 || bus.rsp_obs_idx !== 4'd1 ||
          bus.rsp_last !== 1'b1 || chk_code !== 15'h0021) begin
        fails++;
        $display("FAIL bp_hold%0d: vld=%b code=%h blk=%b idx=%0d chk=%h want 1/0021/1/1/0021",
                 k, bus.rsp_valid, bus.rsp_code, bus.rsp_blocked,
                 bus.rsp_obs_idx, chk_code);
      end
    end
    noise = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tests++;
    if (bus.rsp_valid !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: vld=%b done=%b want 0/1", bus.rsp_valid, done);
    end
    tick();
  endtask

  task automatic test_zero_count();
    accept(15'h0005, 16'd0);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL zero_accept: done=%b busy=%b vld=%b rdy=%b want 1/0/0/1",
               done, busy, bus.rsp_valid, bus.req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL zero_quiet%0d: done=%b busy=%b vld=%b want 0/0/0",
                 k, done, busy, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int n;
    bus.rsp_ready = 1'b1;
    accept(15'h0040, 16'd5);
    wait_rsp(ok, n);
    tick();
    wait_rsp(ok, n);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        bus.req_ready !== 1'b1 || chk_code !== 15'h0041) begin
      fails++;
      $display("FAIL abort_idle: vld=%b busy=%b done=%b rdy=%b chk=%h want 0/0/0/1/0041",
               bus.rsp_valid, busy, done, bus.req_ready, chk_code);
    end
    abort = 1'b1;
    accept(15'h0050, 16'd1);
    abort = 1'b0;
    tests++;
    if (busy !== 1'b1 || chk_code !== 15'h0050) begin
      fails++;
      $display("FAIL abort_reaccept: busy=%b chk=%h want 1/0050", busy, chk_code);
    end
    wait_rsp(ok, n);
    tests++;
    if (!ok || bus.rsp_code !== 15'h0050 || bus.rsp_last !== 1'b1 ||
        bus.rsp_blocked !== 1'b0) begin
      fails++;
      $display("FAIL abort_next_rsp: ok=%0d code=%h last=%b blk=%b want 0050/1/0",
               ok, bus.rsp_code, bus.rsp_last, bus.rsp_blocked);
    end
    tick();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL abort_next_done: got %b want 1", done);
    end
`ifdef PRM_EDGE_HIT_CNT_EN
    tests++;
    if (hit_cnt !== 16'd0) begin
      fails++;
      $display("FAIL abort_hit_cnt: got %0d want 0", hit_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    bus.rsp_ready = 1'b1;
    accept(15'h0033, 16'd2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (chk_code !== '0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_code !== '0) begin
      fails++;
      $display("FAIL rst_mid_clear: chk=%h vld=%b busy=%b done=%b rdy=%b want all 0",
               chk_code, bus.rsp_valid, busy, done, bus.req_ready);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_release: rdy=%b done=%b busy=%b want 1/0/0",
               bus.req_ready, done, busy);
    end
    accept(15'h0100, 16'd1);
    wait_rsp(ok, n);
    tests++;
    if (!ok || bus.rsp_code !== 15'h0100 || bus.rsp_last !== 1'b1 ||
        bus.rsp_blocked !== 1'b0 || bus.rsp_obs_idx !== 4'd0) begin
      fails++;
      $display("FAIL rst_mid_sweep: ok=%0d code=%h last=%b blk=%b want 0100/1/0",
               ok, bus.rsp_code, bus.rsp_last, bus.rsp_blocked);
    end
    tick();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_done: done=%b busy=%b want 1/0", done, busy);
    end
    tick();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_base  = '0;
    bus.req_count = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
